// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums 1..16 unsigned 8-bit products into a
// saturating ACC_W-bit accumulator and hands the result off over valid/ready.
module product_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [4:0]       rem, rem_nxt;
  logic             sat, sat_nxt;
  logic [ACC_W:0]   sum_wide;
  logic [4:0]       run_len;

  // One extra bit makes overflow visible before it could wrap.
  assign sum_wide = {1'b0, acc} + {{(ACC_W-7){1'b0}}, in_prod};
  assign run_len  = {(len == 4'd0), len};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      sat   <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    sat_nxt   = sat;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          sat_nxt   = 1'b0;
          rem_nxt   = run_len;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
          sat_nxt = sat | sum_wide[ACC_W];
          rem_nxt = rem - 5'd1;
          if (rem == 5'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        // Output beat with start chains straight into the next run.
        if (out_ready) begin
          if (start) begin
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
            rem_nxt   = run_len;
            state_nxt = ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_sat   = sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 12-bit and a 10-bit instance
// share stimulus; table of runs plus back-to-back and mid-run reset sequences.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [3:0]  len;
  logic [7:0]  in_prod;
  logic        in_ready, out_valid, out_sat, busy;
  logic [11:0] out_sum;
  logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
  logic [9:0]  out_sum_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(12)) u_acc12 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat), .busy(busy)
  );

  product_accumulator #(.ACC_W(10)) u_acc10 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_sat(out_sat_b), .busy(busy_b)
  );

  typedef struct {
    logic [3:0]        len;
    logic [15:0][7:0]  prod;
    logic [15:0]       gap;    // bit i: one idle cycle before beat i
    int                stall;  // cycles of out_ready=0 in DONE
    int                sum12;
    int                sat12;
    int                sum10;
    int                sat10;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(logic [3:0] l, logic [7:0] p, logic [15:0] g,
                              int st, int s12, int t12, int s10, int t10);
    vec_t v;
    v.len = l;
    for (int i = 0; i < 16; i++) v.prod[i] = p;
    v.gap = g; v.stall = st;
    v.sum12 = s12; v.sat12 = t12; v.sum10 = s10; v.sat10 = t10;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts a run, feeds it (start held high during gaps to prove it is
  // ignored), checks latency, result and stall stability, optionally consumes.
  task automatic run(input vec_t v, input bit consume);
    int nb, cyc, exp_cyc, k;
    logic [11:0] held;
    nb = (v.len == 4'd0) ? 16 : int'(v.len);
    exp_cyc = nb + 1;
    for (int i = 0; i < nb; i++) if (v.gap[i]) exp_cyc++;
    start = 1'b1; len = v.len; in_valid = 1'b0;
    step;
    cyc = 1;
    chk("in_ready_after_start", int'(in_ready), 1);
    for (int i = 0; i < nb; i++) begin
      start = v.gap[i];
      if (v.gap[i]) begin
        in_valid = 1'b0;
        step; cyc++;
      end
      in_valid = 1'b1; in_prod = v.prod[i];
      step; cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin step; cyc++; k++; end
    chk("latency", cyc, exp_cyc);
    chk("in_ready_done", int'(in_ready), 0);
    chk("sum12", int'(out_sum), v.sum12);
    chk("sat12", int'(out_sat), v.sat12);
    chk("sum10", int'(out_sum_b), v.sum10);
    chk("sat10", int'(out_sat_b), v.sat10);
    held = out_sum;
    for (int s = 0; s < v.stall; s++) begin
      start = 1'b1;
      step;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_sum", int'(out_sum), int'(held));
    end
    start = 1'b0;
    if (consume) begin
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      chk("consumed_valid", int'(out_valid), 0);
      chk("consumed_busy", int'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
    in_prod = 8'd0; out_ready = 1'b0;

    tbl[0] = mk(4'd4,  8'd0,   16'h0000, 0, 24,   0, 24,   0);
    tbl[0].prod[0] = 8'd3; tbl[0].prod[1] = 8'd5;
    tbl[0].prod[2] = 8'd7; tbl[0].prod[3] = 8'd9;
    tbl[1] = mk(4'd0,  8'd225, 16'h0000, 0, 3600, 0, 1023, 1);
    tbl[2] = mk(4'd5,  8'd225, 16'h0016, 3, 1125, 0, 1023, 1);
    tbl[3] = mk(4'd1,  8'd255, 16'h0000, 0, 255,  0, 255,  0);
    tbl[4] = mk(4'd15, 8'd255, 16'h5A5A, 7, 3825, 0, 1023, 1);
    tbl[5] = mk(4'd3,  8'd0,   16'h0001, 2, 0,    0, 0,    0);

    step; step;
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) run(tbl[i], 1'b1);

    // Back-to-back: consume and restart in the same DONE cycle.
    run(tbl[0], 1'b0);
    start = 1'b1; len = 4'd2; out_ready = 1'b1;
    step;
    start = 1'b0; out_ready = 1'b0;
    chk("b2b_in_ready", int'(in_ready), 1);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_out_valid", int'(out_valid), 0);
    in_valid = 1'b1; in_prod = 8'd10;
    step;
    in_prod = 8'd20;
    step;
    in_valid = 1'b0;
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_sum", int'(out_sum), 30);
    chk("b2b_sat", int'(out_sat), 0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;

    // Reset mid-run discards partial sum.
    start = 1'b1; len = 4'd4;
    step;
    start = 1'b0; in_valid = 1'b1; in_prod = 8'd50;
    step; step;
    in_valid = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_sum", int'(out_sum), 0);
    run(mk(4'd1, 8'd8, 16'h0000, 0, 8, 0, 8, 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
